// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and Q8.8 constants used by the MAC, the operand
// sequencer and the layer controller.
package cnn_pkg;

    typedef enum logic [1:0] {
        LAYER_CONV1 = 2'd0,
        LAYER_CONV2 = 2'd1,
        LAYER_FC    = 2'd2
    } layer_t;

    localparam int CONV_TERMS = 25;
    localparam int FC_TERMS   = 192;

    localparam int FRAC_BITS  = 8;
    localparam int Q_MAX      = 32767;
    localparam int Q_MIN      = -32768;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_DRAIN   = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESULT  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/requant_sat.sv
// Combinational requantiser: Q16.16 accumulator + Q8.8 bias -> saturated Q8.8.
// Build option RELU_EN clamps negative results to zero after saturation.
module requant_sat
    import cnn_pkg::*;
#(
    parameter int ACC_W     = 32,
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] bias,
    output logic [DATA_W-1:0] res
);

    localparam int SW = ACC_W + 1;
    localparam logic signed [SW-1:0] SAT_MAX = SW'(Q_MAX);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(Q_MIN);

    logic signed [SW-1:0] acc_x;
    logic signed [SW-1:0] bias_x;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shifted;
    logic        [DATA_W-1:0] sat_v;

    function automatic logic [DATA_W-1:0] saturate(input logic signed [SW-1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[DATA_W-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[DATA_W-1:0];
        else
            return v[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] v);
`ifdef RELU_EN
        return v[DATA_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // One guard bit above the accumulator keeps acc + bias from wrapping.
    assign acc_x   = SW'($signed(acc));
    assign bias_x  = SW'($signed(bias)) <<< FRAC_BITS;
    assign sum     = acc_x + bias_x;
    assign shifted = sum >>> FRAC_BITS;
    assign sat_v   = saturate(shifted);
    assign res     = relu(sat_v);

endmodule

// File: rtl/mac_operand_sequencer.sv
// MAC operand sequencer: streams conv/FC operand pairs to the shared MAC, then
// requantises the accumulator and offers it on a valid/ready port. Option: RELU_EN.
module mac_operand_sequencer
    import cnn_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 32,
    parameter int FRAC_BITS = 8,
    parameter int KERNEL    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        layer,
    input  logic [ADDR_W-1:0] win_base,
    input  logic [ADDR_W-1:0] row_w,
    input  logic [ADDR_W-1:0] wt_base,
    input  logic [DATA_W-1:0] bias,
    output logic [ADDR_W-1:0] fm_addr,
    output logic [ADDR_W-1:0] wt_addr,
    input  logic [DATA_W-1:0] fm_rdata,
    input  logic [DATA_W-1:0] wt_rdata,
    output logic              mac_en,
    output logic [1:0]        mac_layer,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic [ACC_W-1:0]  mac_acc,
    output logic [DATA_W-1:0] res_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
    output logic              err
);

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [7:0]        CONV_LAST = 8'(KERNEL * KERNEL - 1);
    localparam logic [7:0]        FC_LAST   = 8'(FC_TERMS - 1);
    localparam logic [7:0]        COL_LAST  = 8'(KERNEL - 1);

    seq_state_t        state;
    logic [1:0]        lay_q;
    logic [ADDR_W-1:0] row_w_q;
    logic [ADDR_W-1:0] row_addr;
    logic [DATA_W-1:0] bias_q;
    logic [7:0]        k;
    logic [7:0]        col;
    logic [7:0]        last_k;
    logic              is_fc;
    logic [DATA_W-1:0] rq_data;

    assign mac_a  = fm_rdata;
    assign mac_b  = wt_rdata;
    assign is_fc  = (lay_q == LAYER_FC);
    assign last_k = is_fc ? FC_LAST : CONV_LAST;

    requant_sat #(
        .ACC_W     (ACC_W),
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_requant (
        .acc  (mac_acc),
        .bias (bias_q),
        .res  (rq_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            lay_q     <= '0;
            row_w_q   <= '0;
            row_addr  <= '0;
            bias_q    <= '0;
            k         <= '0;
            col       <= '0;
            fm_addr   <= '0;
            wt_addr   <= '0;
            mac_en    <= 1'b0;
            mac_layer <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            err    <= 1'b0;
            // Read data for the address shown this cycle arrives next cycle.
            mac_en <= (state == S_ISSUE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (layer == 2'd3) begin
                            err <= 1'b1;
                        end else begin
                            lay_q     <= layer;
                            mac_layer <= layer;
                            row_w_q   <= row_w;
                            bias_q    <= bias;
                            fm_addr   <= win_base;
                            row_addr  <= win_base;
                            wt_addr   <= wt_base;
                            k         <= '0;
                            col       <= '0;
                            busy      <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (k == last_k) begin
                        state <= S_DRAIN;
                    end else begin
                        k       <= k + 8'd1;
                        wt_addr <= wt_addr + ADDR_ONE;
                        if (is_fc) begin
                            fm_addr <= fm_addr + ADDR_ONE;
                        end else if (col == COL_LAST) begin
                            // End of a window row: jump to the next row's left edge.
                            col      <= '0;
                            row_addr <= row_addr + row_w_q;
                            fm_addr  <= row_addr + row_w_q;
                        end else begin
                            col     <= col + 8'd1;
                            fm_addr <= fm_addr + ADDR_ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    // mac_acc is only valid this cycle; the MAC clears on the next edge.
                    res_data  <= rq_data;
                    res_valid <= 1'b1;
                    state     <= S_RESULT;
                end
                S_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Scoreboard bench for mac_operand_sequencer with a saturating MAC model and
// 1-cycle-latency RAM/ROM models.
module tb_mac_operand_sequencer;

    typedef struct {
        logic [15:0] data;
        int          rise;
        int          n;
    } exp_t;

    typedef struct {
        logic [15:0] fm;
        logic [15:0] wt;
    } addr_t;

`ifdef RELU_EN
    localparam logic [15:0] NEG_EXP    = 16'h0000;
    localparam logic [15:0] NEGSAT_EXP = 16'h0000;
`else
    localparam logic [15:0] NEG_EXP    = 16'hE700;
    localparam logic [15:0] NEGSAT_EXP = 16'h8000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  layer = 2'd0;
    logic [15:0] win_base = '0, row_w = '0, wt_base = '0, bias = '0;
    logic [15:0] fm_addr, wt_addr, mac_a, mac_b, res_data;
    logic [15:0] fm_rdata = '0, wt_rdata = '0;
    logic [15:0] fm_fill = '0, wt_fill = '0;
    logic [31:0] mac_acc = '0;
    logic        mac_en, res_valid, busy, err;
    logic [1:0]  mac_layer;
    logic        res_ready = 1'b1;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t  sq[$];
    addr_t aq[$];

    always #5 clk = ~clk;

    mac_operand_sequencer #(
        .ADDR_W(16), .DATA_W(16), .ACC_W(32), .FRAC_BITS(8), .KERNEL(5)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .layer(layer),
        .win_base(win_base), .row_w(row_w), .wt_base(wt_base), .bias(bias),
        .fm_addr(fm_addr), .wt_addr(wt_addr), .fm_rdata(fm_rdata), .wt_rdata(wt_rdata),
        .mac_en(mac_en), .mac_layer(mac_layer), .mac_a(mac_a), .mac_b(mac_b),
        .mac_acc(mac_acc), .res_data(res_data), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy), .err(err)
    );

    function automatic logic [31:0] mac_step(input logic [31:0] acc, input logic [15:0] a,
                                             input logic [15:0] b);
        logic signed [63:0] t;
        t = 64'($signed(acc)) + 64'($signed(a)) * 64'($signed(b));
        if (t > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (t < -64'sd2147483648) return 32'h8000_0000;
        return t[31:0];
    endfunction

    // Shared MAC: accumulates while enabled, clears otherwise.
    always @(posedge clk or posedge reset) begin
        if (reset) mac_acc <= '0;
        else if (mac_en) mac_acc <= mac_step(mac_acc, mac_a, mac_b);
        else mac_acc <= '0;
    end

    always @(posedge clk) begin
        fm_rdata <= fm_fill;
        wt_rdata <= wt_fill;
        cyc      <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: address order per mac_en cycle, result data/latency/term count at handshake.
    logic [15:0] prev_fm = '0, prev_wt = '0;
    logic        prev_valid = 1'b0;
    int          mac_cnt = 0;
    int          rise_cyc = -1;
    always @(negedge clk) begin
        if (reset) begin
            mac_cnt    = 0;
            rise_cyc   = -1;
            prev_valid = 1'b0;
        end else begin
            if (mac_en) begin
                mac_cnt++;
                if (aq.size() > 0) begin
                    addr_t a;
                    a = aq.pop_front();
                    chk("fm_addr order", 32'(prev_fm), 32'(a.fm));
                    chk("wt_addr order", 32'(prev_wt), 32'(a.wt));
                end
            end
            prev_fm = fm_addr;
            prev_wt = wt_addr;
            if (res_valid && !prev_valid) rise_cyc = cyc;
            prev_valid = res_valid;
            if (res_valid && res_ready) begin
                if (sq.size() == 0) begin
                    chk("unexpected result", 32'(res_data), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sq.pop_front();
                    chk("res_data", 32'(res_data), 32'(e.data));
                    chk("res_valid latency", 32'(rise_cyc), 32'(e.rise));
                    chk("mac_en count", 32'(mac_cnt), 32'(e.n));
                end
                mac_cnt = 0;
            end
        end
    end

    task automatic run_op(input logic [1:0] lay, input logic [15:0] wb, input logic [15:0] rw,
                          input logic [15:0] wtb, input logic [15:0] bs, input logic [15:0] fmv,
                          input logic [15:0] wtv, input logic [15:0] expd, input int n);
        fm_fill  = fmv;
        wt_fill  = wtv;
        layer    = lay;
        win_base = wb;
        row_w    = rw;
        wt_base  = wtb;
        bias     = bs;
        start    = 1'b1;
        sq.push_back('{data: expd, rise: cyc + n + 3, n: n});
        @(posedge clk); #1;
        start = 1'b0;
        chk("mac_layer", 32'(mac_layer), 32'(lay));
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (sq.size() != 0 && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        if (sq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: timed out after %0d cycles, %0d results outstanding", name, t, sq.size());
            sq.delete();
        end
    endtask

    initial begin
        int rows[5];
        rows = '{10, 38, 66, 94, 122};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset fm_addr", 32'(fm_addr), 32'h0);
        chk("reset wt_addr", 32'(wt_addr), 32'h0);
        chk("reset mac_en", 32'(mac_en), 32'h0);
        chk("reset res_data", 32'(res_data), 32'h0);
        chk("reset res_valid", 32'(res_valid), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset err", 32'(err), 32'h0);
        chk("reset mac_layer", 32'(mac_layer), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Conv, 1.0 * 0.5 everywhere -> 12.5, window base 10 pitch 28.
        for (int r = 0; r < 5; r++)
            for (int j = 0; j < 5; j++)
                aq.push_back('{fm: 16'(rows[r] + j), wt: 16'(100 + r * 5 + j)});
        run_op(2'd0, 16'd10, 16'd28, 16'd100, 16'h0000, 16'h0100, 16'h0080, 16'h0C80, 25);
        wait_done("conv positive");

        run_op(2'd1, 16'd200, 16'd40, 16'd0, 16'h0000, 16'hFF00, 16'h0100, NEG_EXP, 25);
        wait_done("conv negative");

        run_op(2'd0, 16'd0, 16'd16, 16'd0, 16'hFE00, 16'h0100, 16'h0080, 16'h0A80, 25);
        wait_done("conv with bias");

        run_op(2'd0, 16'd0, 16'd16, 16'd0, 16'h0000, 16'h8000, 16'h7FFF, NEGSAT_EXP, 25);
        wait_done("conv negative saturation");

        // FC with addresses wrapping past 0xFFFF.
        for (int k = 0; k < 192; k++)
            aq.push_back('{fm: 16'(16'hFFF0 + k), wt: 16'(16'hFFA0 + k)});
        run_op(2'd2, 16'hFFF0, 16'd0, 16'hFFA0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 192);
        wait_done("fc saturation");

        // Illegal layer.
        layer = 2'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err pulse", 32'(err), 32'h1);
        chk("err busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        chk("err one cycle", 32'(err), 32'h0);

        // Back-pressure.
        res_ready = 1'b0;
        run_op(2'd0, 16'd0, 16'd16, 16'd0, 16'h0000, 16'h0100, 16'h0080, 16'h0C80, 25);
        begin
            int t = 0;
            while (!res_valid && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
            chk("bp res_valid rise", 32'(res_valid), 32'h1);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                layer = 2'd2;
                start = 1'b1;
            end
            if (i == 4) start = 1'b0;
            @(posedge clk); #1;
            if (i == 0 || i == 9) begin
                chk("bp res_data stable", 32'(res_data), 32'h0C80);
                chk("bp busy", 32'(busy), 32'h1);
            end
        end
        res_ready = 1'b1;
        wait_done("back-pressure");
        chk("bp idle busy", 32'(busy), 32'h0);
        chk("bp idle res_valid", 32'(res_valid), 32'h0);

        // Reset mid-ISSUE.
        run_op(2'd0, 16'd0, 16'd16, 16'd0, 16'h0000, 16'h0100, 16'h0080, 16'h0C80, 25);
        repeat (8) @(posedge clk);
        #1;
        chk("pre-reset mac_en", 32'(mac_en), 32'h1);
        reset = 1'b1;
        #1;
        chk("mid reset mac_en", 32'(mac_en), 32'h0);
        chk("mid reset busy", 32'(busy), 32'h0);
        chk("mid reset fm_addr", 32'(fm_addr), 32'h0);
        sq.delete();
        aq.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(2'd1, 16'd50, 16'd20, 16'd7, 16'h0100, 16'h0100, 16'h0080, 16'h0D80, 25);
        wait_done("after reset");

        repeat (40) @(posedge clk);
        #1;
        chk("no stray result", 32'(res_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
